// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, shifter/rotated-immediate operand
// generation, ALU with NZCV flags, branch target adder, and the registered
// EXE/MEM payload plus status register.
// Optional feature macro: EXE_FORWARD_EN (enables src1/src2 forwarding muxes).
module exe_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_en_in,
   input  logic        mem_r_en_in,
   input  logic        mem_w_en_in,
   input  logic [3:0]  exe_cmd,
   input  logic        b_in,
   input  logic        s_in,
   input  logic [31:0] pc_in,
   input  logic [31:0] val1,
   input  logic [31:0] val_rm,
   input  logic        imm,
   input  logic [11:0] shift_operand,
   input  logic [23:0] signed_imm,
   input  logic [3:0]  dest_in,
   input  logic        c_in,
   input  logic        mem_stall,
   input  logic [1:0]  sel_src1,
   input  logic [1:0]  sel_src2,
   input  logic [31:0] mem_fwd_val,
   input  logic [31:0] wb_fwd_val,
   output logic        branch_taken,
   output logic [31:0] branch_addr,
   output logic [3:0]  status,
   output logic        wb_en_out,
   output logic        mem_r_en_out,
   output logic        mem_w_en_out,
   output logic [31:0] alu_res,
   output logic [31:0] st_val,
   output logic [3:0]  dest_out
);

   logic [31:0] w_src1;
   logic [31:0] w_src2;
   logic [31:0] w_val2;
   logic [31:0] w_res;
   logic [32:0] w_sum;
   logic        w_n, w_z, w_c, w_v;
   logic        w_flag_upd;

   logic [3:0]  r_status;
   logic        r_wb_en;
   logic        r_mem_r_en;
   logic        r_mem_w_en;
   logic [31:0] r_alu_res;
   logic [31:0] r_st_val;
   logic [3:0]  r_dest;

`ifdef EXE_FORWARD_EN
   // Source operand forwarding muxes; 11 falls back to the pipeline value
   always_comb begin
      case (sel_src1)
         2'b01:   w_src1 = mem_fwd_val;
         2'b10:   w_src1 = wb_fwd_val;
         default: w_src1 = val1;
      endcase
      case (sel_src2)
         2'b01:   w_src2 = mem_fwd_val;
         2'b10:   w_src2 = wb_fwd_val;
         default: w_src2 = val_rm;
      endcase
   end
`else
   logic w_unused_fwd;
   assign w_unused_fwd = ^{sel_src1, sel_src2, mem_fwd_val, wb_fwd_val};
   assign w_src1 = val1;
   assign w_src2 = val_rm;
`endif

   // Second operand: rotated immediate, memory offset, or shifted register.
   // Rotates use a doubled word so a zero amount passes through unchanged.
   logic [31:0] w_imm32;
   logic [4:0]  w_rot;
   logic [4:0]  w_sh;
   logic [63:0] w_imm_dbl;
   logic [63:0] w_rm_dbl;
   always_comb begin
      w_imm32   = {24'd0, shift_operand[7:0]};
      w_rot     = {shift_operand[11:8], 1'b0};
      w_sh      = shift_operand[11:7];
      w_imm_dbl = {w_imm32, w_imm32} >> w_rot;
      w_rm_dbl  = {w_src2, w_src2} >> w_sh;
      w_val2    = 32'd0;
      if (imm) begin
         w_val2 = w_imm_dbl[31:0];
      end else if (mem_r_en_in || mem_w_en_in) begin
         w_val2 = {20'd0, shift_operand};
      end else begin
         case (shift_operand[6:5])
            2'b00:   w_val2 = w_src2 << w_sh;
            2'b01:   w_val2 = w_src2 >> w_sh;
            2'b10:   w_val2 = $signed(w_src2) >>> w_sh;
            default: w_val2 = w_rm_dbl[31:0];
         endcase
      end
   end

   // ALU and flag generation; subtraction is done as src1 + ~val2 + carry
   // so the carry-out is directly NOT-borrow
   always_comb begin
      w_res      = 32'd0;
      w_sum      = 33'd0;
      w_c        = r_status[1];
      w_v        = r_status[0];
      w_flag_upd = 1'b1;
      case (exe_cmd)
         4'b0001: w_res = w_val2;
         4'b1001: w_res = ~w_val2;
         4'b0010, 4'b0011: begin
            w_sum = {1'b0, w_src1} + {1'b0, w_val2}
                  + {32'd0, (exe_cmd[0] & c_in)};
            w_res = w_sum[31:0];
            w_c   = w_sum[32];
            w_v   = (w_src1[31] == w_val2[31]) && (w_res[31] != w_src1[31]);
         end
         4'b0100, 4'b0101: begin
            w_sum = {1'b0, w_src1} + {1'b0, ~w_val2}
                  + {32'd0, (exe_cmd[0] ? c_in : 1'b1)};
            w_res = w_sum[31:0];
            w_c   = w_sum[32];
            w_v   = (w_src1[31] != w_val2[31]) && (w_res[31] != w_src1[31]);
         end
         4'b0110: w_res = w_src1 & w_val2;
         4'b0111: w_res = w_src1 | w_val2;
         4'b1000: w_res = w_src1 ^ w_val2;
         default: begin
            w_res      = 32'd0;
            w_flag_upd = 1'b0;
         end
      endcase
      w_n = w_res[31];
      w_z = (w_res == 32'd0);
   end

   // Branch resolution goes straight back to fetch
   assign branch_taken = b_in;
   assign branch_addr  = pc_in + {{6{signed_imm[23]}}, signed_imm, 2'b00};

   // Status flags: branch wins over s_in; stall and undefined ops hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_status <= 4'd0;
      end else if (!mem_stall && s_in && !b_in && w_flag_upd) begin
         r_status <= {w_n, w_z, w_c, w_v};
      end
   end

   // EXE/MEM payload register; a branch squashes the write/memory enables
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wb_en    <= 1'b0;
         r_mem_r_en <= 1'b0;
         r_mem_w_en <= 1'b0;
         r_alu_res  <= 32'd0;
         r_st_val   <= 32'd0;
         r_dest     <= 4'd0;
      end else if (!mem_stall) begin
         r_wb_en    <= wb_en_in    & ~b_in;
         r_mem_r_en <= mem_r_en_in & ~b_in;
         r_mem_w_en <= mem_w_en_in & ~b_in;
         r_alu_res  <= w_res;
         r_st_val   <= w_src2;
         r_dest     <= dest_in;
      end
   end

   assign status       = r_status;
   assign wb_en_out    = r_wb_en;
   assign mem_r_en_out = r_mem_r_en;
   assign mem_w_en_out = r_mem_w_en;
   assign alu_res      = r_alu_res;
   assign st_val       = r_st_val;
   assign dest_out     = r_dest;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: expected payloads are queued when an
// instruction is driven and checked one cycle later.
module tb_exe_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_en_in, mem_r_en_in, mem_w_en_in;
   logic [3:0]  exe_cmd;
   logic        b_in, s_in;
   logic [31:0] pc_in, val1, val_rm;
   logic        imm;
   logic [11:0] shift_operand;
   logic [23:0] signed_imm;
   logic [3:0]  dest_in;
   logic        c_in, mem_stall;
   logic [1:0]  sel_src1, sel_src2;
   logic [31:0] mem_fwd_val, wb_fwd_val;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic [3:0]  status;
   logic        wb_en_out, mem_r_en_out, mem_w_en_out;
   logic [31:0] alu_res, st_val;
   logic [3:0]  dest_out;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] st;
      logic [3:0]  dest;
      logic [3:0]  nzcv;
      logic        wb;
      logic        mr;
      logic        mw;
   } exp_t;

   exp_t sb[$];
   exp_t last_exp;
   int   checks = 0;
   int   failures = 0;

   exe_stage dut (
      .clk(clk), .rst(rst),
      .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
      .exe_cmd(exe_cmd), .b_in(b_in), .s_in(s_in), .pc_in(pc_in),
      .val1(val1), .val_rm(val_rm), .imm(imm), .shift_operand(shift_operand),
      .signed_imm(signed_imm), .dest_in(dest_in), .c_in(c_in),
      .mem_stall(mem_stall), .sel_src1(sel_src1), .sel_src2(sel_src2),
      .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val),
      .branch_taken(branch_taken), .branch_addr(branch_addr), .status(status),
      .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
      .mem_w_en_out(mem_w_en_out), .alu_res(alu_res), .st_val(st_val),
      .dest_out(dest_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input exp_t e);
      chk({tag, ".alu_res"}, alu_res, e.alu);
      chk({tag, ".st_val"}, st_val, e.st);
      chk({tag, ".dest"}, {28'd0, dest_out}, {28'd0, e.dest});
      chk({tag, ".status"}, {28'd0, status}, {28'd0, e.nzcv});
      chk({tag, ".en"}, {29'd0, wb_en_out, mem_r_en_out, mem_w_en_out},
          {29'd0, e.wb, e.mr, e.mw});
   endtask

   task automatic idle();
      wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; exe_cmd = 4'd0;
      b_in = 0; s_in = 0; pc_in = 0; val1 = 0; val_rm = 0; imm = 0;
      shift_operand = 0; signed_imm = 0; dest_in = 0; c_in = 0;
      mem_stall = 0; sel_src1 = 0; sel_src2 = 0; mem_fwd_val = 0; wb_fwd_val = 0;
   endtask

   task automatic op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] rm,
                     input logic im, input logic [11:0] so, input logic s, input logic [3:0] d);
      idle();
      exe_cmd = cmd; val1 = a; val_rm = rm; imm = im; shift_operand = so;
      s_in = s; dest_in = d; wb_en_in = 1'b1;
   endtask

   task automatic push(input logic [31:0] alu, input logic [31:0] st, input logic [3:0] d,
                       input logic [3:0] nzcv, input logic wb, input logic mr, input logic mw);
      exp_t e;
      e.alu = alu; e.st = st; e.dest = d; e.nzcv = nzcv; e.wb = wb; e.mr = mr; e.mw = mw;
      sb.push_back(e);
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      #1;
      checks++;
      assert (sb.size() != 0) else begin
         failures++;
         $error("FAIL %s observed=empty_queue expected=entry", tag);
      end
      if (sb.size() != 0) begin
         last_exp = sb.pop_front();
         chk_out(tag, last_exp);
      end
   endtask

   initial begin
      exp_t zero_e;
      zero_e = '0;
      idle();
      rst = 1'b1;
      #12;
      chk_out("reset", zero_e);
      rst = 1'b0;

      op(4'b0010, 32'h7FFF_FFFF, 32'h1234, 1, 12'h001, 1, 4'd3);
      push(32'h8000_0000, 32'h1234, 4'd3, 4'b1001, 1, 0, 0);
      tick("add_ovf");

      op(4'b0100, 32'd5, 32'd5, 0, 12'h000, 1, 4'd4);
      push(32'd0, 32'd5, 4'd4, 4'b0110, 1, 0, 0);
      tick("sub_cmp");

      op(4'b0001, 32'd0, 32'd7, 1, 12'h4FF, 1, 4'd5);
      push(32'hFF00_0000, 32'd7, 4'd5, 4'b1010, 1, 0, 0);
      tick("mov_rot");

      op(4'b0010, 32'd1, 32'd9, 1, 12'h001, 1, 4'd6);
      mem_stall = 1'b1;
      @(posedge clk); #1;
      chk_out("stall_hold", last_exp);

      op(4'b0010, 32'd1, 32'd9, 1, 12'h001, 1, 4'd7);
      b_in = 1'b1; pc_in = 32'h100; signed_imm = 24'hFFFFFE;
      #1;
      chk("br_addr", branch_addr, 32'h0000_00F8);
      chk("br_taken", {31'd0, branch_taken}, 32'd1);
      push(32'd2, 32'd9, 4'd7, 4'b1010, 0, 0, 0);
      tick("branch");

      op(4'b0001, 0, 32'h8000_0001, 0, 12'h220, 0, 4'd1);
      push(32'h0800_0000, 32'h8000_0001, 4'd1, 4'b1010, 1, 0, 0);
      tick("lsr4");
      op(4'b0001, 0, 32'h8000_0001, 0, 12'h240, 0, 4'd1);
      push(32'hF800_0000, 32'h8000_0001, 4'd1, 4'b1010, 1, 0, 0);
      tick("asr4");
      op(4'b0001, 0, 32'h8000_0001, 0, 12'h260, 0, 4'd1);
      push(32'h1800_0000, 32'h8000_0001, 4'd1, 4'b1010, 1, 0, 0);
      tick("ror4");
      op(4'b0001, 0, 32'h8000_0001, 0, 12'h200, 0, 4'd1);
      push(32'h0000_0010, 32'h8000_0001, 4'd1, 4'b1010, 1, 0, 0);
      tick("lsl4");
      op(4'b0001, 0, 32'h8000_0001, 0, 12'h060, 0, 4'd1);
      push(32'h8000_0001, 32'h8000_0001, 4'd1, 4'b1010, 1, 0, 0);
      tick("ror0");

      op(4'b0010, 32'h100, 32'hDEAD, 0, 12'hABC, 0, 4'd2);
      wb_en_in = 0; mem_w_en_in = 1;
      push(32'h0000_0BBC, 32'hDEAD, 4'd2, 4'b1010, 0, 0, 1);
      tick("mem_off");

      op(4'b0100, 32'd5, 32'd5, 0, 12'h000, 1, 4'd0);
      push(32'd0, 32'd5, 4'd0, 4'b0110, 1, 0, 0);
      tick("sub_c1");
      op(4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 12'h000, 1, 4'd0);
      push(32'hF000_F000, 32'hFF00_FF00, 4'd0, 4'b1010, 1, 0, 0);
      tick("and");
      op(4'b1000, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 12'h000, 1, 4'd0);
      push(32'h0FF0_0FF0, 32'hFF00_FF00, 4'd0, 4'b0010, 1, 0, 0);
      tick("eor");
      op(4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 12'h000, 1, 4'd0);
      push(32'hFFF0_FFF0, 32'hFF00_FF00, 4'd0, 4'b1010, 1, 0, 0);
      tick("orr");
      op(4'b1001, 0, 32'hFFFF_FFFF, 0, 12'h000, 1, 4'd0);
      push(32'd0, 32'hFFFF_FFFF, 4'd0, 4'b0110, 1, 0, 0);
      tick("mvn");
      op(4'b1111, 32'd3, 32'd4, 0, 12'h000, 1, 4'd0);
      push(32'd0, 32'd4, 4'd0, 4'b0110, 1, 0, 0);
      tick("undef");

      op(4'b0011, 32'hFFFF_FFFF, 32'd0, 1, 12'h001, 1, 4'd8);
      c_in = 1'b1;
      push(32'd1, 32'd0, 4'd8, 4'b0010, 1, 0, 0);
      tick("adc");
      op(4'b0101, 32'd0, 32'd0, 1, 12'h001, 1, 4'd9);
      c_in = 1'b0;
      push(32'hFFFF_FFFE, 32'd0, 4'd9, 4'b1000, 1, 0, 0);
      tick("sbc");

      op(4'b0010, 32'd9, 32'h66, 1, 12'h001, 0, 4'd10);
      sel_src1 = 2'b01; mem_fwd_val = 32'd3; sel_src2 = 2'b10; wb_fwd_val = 32'h55;
`ifdef EXE_FORWARD_EN
      push(32'd4, 32'h55, 4'd10, 4'b1000, 1, 0, 0);
`else
      push(32'd10, 32'h66, 4'd10, 4'b1000, 1, 0, 0);
`endif
      tick("fwd");

      op(4'b0010, 32'd1, 32'd2, 1, 12'h001, 1, 4'd11);
      mem_stall = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      chk_out("rst_async", zero_e);
      @(posedge clk); #1;
      chk_out("rst_hold", zero_e);
      rst = 1'b0;
      op(4'b0010, 32'd1, 32'd2, 1, 12'h001, 1, 4'd11);
      push(32'd2, 32'd2, 4'd11, 4'b0000, 1, 0, 0);
      tick("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
